// File: rtl/cache_bus_pkg.sv
// Shared bus encodings for the snooping bus arbiter and the cache_mem controllers.
package cache_bus_pkg;

   typedef enum logic [1:0] {
      BUS_NO_REQ = 2'd0,
      BUS_RD     = 2'd1,
      BUS_RDX    = 2'd2,
      BUS_UPGR   = 2'd3
   } bus_req_e;

   typedef enum logic [1:0] {
      BUS_NO_RSP          = 2'd0,
      BUS_SNOOP_FOUND_RSP = 2'd1,
      BUS_FETCH_MEM_RSP   = 2'd2,
      BUS_UPGR_ACK_RSP    = 2'd3
   } bus_rsp_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SNOOP  = 3'd1,
      WB     = 3'd2,
      MEM_RD = 3'd3,
      RESP   = 3'd4
   } bus_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_CACHE = 4,
   localparam int IDX_W = $clog2(NUM_CACHE)
) (
   input  logic [NUM_CACHE-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_CACHE-1:0] grant,
   output logic [IDX_W-1:0]     grant_idx,
   output logic                 valid
);

   logic [IDX_W-1:0] cand;

   // Scan requesters starting at ptr; the first hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
      cand      = '0;
      for (int unsigned off = 0; off < NUM_CACHE; off++) begin
         cand = IDX_W'((32'(ptr) + off) % NUM_CACHE);
         if (!valid && req[cand]) begin
            valid       = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snooping bus arbiter: serialises cache requests, broadcasts snoops,
// resolves via peer caches or memory and returns one response per grant.
module snoop_bus_arbiter
   import cache_bus_pkg::*;
#(
   parameter int NUM_CACHE  = 4,
   parameter int ADDR_WIDTH = 64,
   parameter int LINE_WIDTH = 512,
   localparam int BLK_W = ADDR_WIDTH - $clog2(LINE_WIDTH/8),
   localparam int IDX_W = $clog2(NUM_CACHE)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_CACHE-1:0][1:0]            cac2bus_bus_req,
   input  logic [NUM_CACHE-1:0][BLK_W-1:0]      cac2bus_addr,
   input  logic [NUM_CACHE-1:0][1:0]            cac2bus_bus_rsp,
   input  logic [NUM_CACHE-1:0]                 cac2bus_write_back,
   input  logic [NUM_CACHE-1:0][LINE_WIDTH-1:0] cac2bus_data,
   output logic [NUM_CACHE-1:0][1:0]            bus2cac_bus_req,
   output logic [NUM_CACHE-1:0][1:0]            bus2cac_bus_rsp,
   output logic [BLK_W-1:0]                     bus2cac_addr,
   output logic [LINE_WIDTH-1:0]                bus2cac_data,
   output logic                                 mem_rd_req,
   output logic                                 mem_wr_req,
   output logic [BLK_W-1:0]                     mem_addr,
   output logic [LINE_WIDTH-1:0]                mem_wdata,
   input  logic                                 mem_ack,
   input  logic [LINE_WIDTH-1:0]                mem_rdata
);

   bus_state_e            state;
   logic [IDX_W-1:0]      rr_ptr;
   logic [IDX_W-1:0]      grant_q;
   logic [1:0]            code_q;
   logic [1:0]            rsp_q;
   logic [BLK_W-1:0]      addr_q;
   logic [LINE_WIDTH-1:0] line_q;

   logic [NUM_CACHE-1:0]  req_vec;
   logic [NUM_CACHE-1:0]  arb_grant;
   logic [IDX_W-1:0]      arb_idx;
   logic                  arb_valid;
   logic [1:0]            sel_code;
   logic [BLK_W-1:0]      sel_addr;

   logic                  wb_any;
   logic [IDX_W-1:0]      wb_idx;
   logic                  found_any;
   logic [IDX_W-1:0]      found_idx;

   // Active requesters plus the granted cache's code/address (one-hot AND-OR mux).
   always_comb begin
      req_vec  = '0;
      sel_code = '0;
      sel_addr = '0;
      for (int unsigned i = 0; i < NUM_CACHE; i++) begin
         req_vec[i] = (cac2bus_bus_req[i] != BUS_NO_REQ);
         if (arb_grant[i]) begin
            sel_code = sel_code | cac2bus_bus_req[i];
            sel_addr = sel_addr | cac2bus_addr[i];
         end
      end
   end

   rr_arbiter #(.NUM_CACHE(NUM_CACHE)) u_rr_arbiter (
      .req       (req_vec),
      .ptr       (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .valid     (arb_valid)
   );

   // Lowest-index dirty owner and lowest-index snoop hit among non-granted caches.
   always_comb begin
      wb_any    = 1'b0;
      wb_idx    = '0;
      found_any = 1'b0;
      found_idx = '0;
      for (int unsigned i = 0; i < NUM_CACHE; i++) begin
         if (IDX_W'(i) != grant_q) begin
            if (!wb_any && cac2bus_write_back[i]) begin
               wb_any = 1'b1;
               wb_idx = IDX_W'(i);
            end
            if (!found_any && cac2bus_bus_rsp[i] == BUS_SNOOP_FOUND_RSP) begin
               found_any = 1'b1;
               found_idx = IDX_W'(i);
            end
         end
      end
   end

   // Transaction FSM: grant, one-cycle snoop, optional write-back or fill, one-cycle response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         grant_q <= '0;
         code_q  <= '0;
         rsp_q   <= '0;
         addr_q  <= '0;
         line_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  grant_q <= arb_idx;
                  code_q  <= sel_code;
                  addr_q  <= sel_addr;
                  state   <= SNOOP;
               end
            end
            SNOOP: begin
               if (wb_any) begin
                  line_q <= cac2bus_data[wb_idx];
                  state  <= WB;
               end else if (found_any) begin
                  line_q <= cac2bus_data[found_idx];
                  rsp_q  <= BUS_SNOOP_FOUND_RSP;
                  state  <= RESP;
               end else if (code_q == BUS_UPGR) begin
                  line_q <= '0;
                  rsp_q  <= BUS_UPGR_ACK_RSP;
                  state  <= RESP;
               end else begin
                  state  <= MEM_RD;
               end
            end
            WB: begin
               if (mem_ack) begin
                  rsp_q <= (code_q == BUS_UPGR) ? BUS_UPGR_ACK_RSP : BUS_SNOOP_FOUND_RSP;
                  state <= RESP;
               end
            end
            MEM_RD: begin
               if (mem_ack) begin
                  line_q <= mem_rdata;
                  rsp_q  <= BUS_FETCH_MEM_RSP;
                  state  <= RESP;
               end
            end
            RESP: begin
               rr_ptr <= (grant_q == IDX_W'(NUM_CACHE-1)) ? '0 : grant_q + 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decoded from state so reset clears them on the following cycle.
   always_comb begin
      bus2cac_bus_req = '0;
      bus2cac_bus_rsp = '0;
      bus2cac_addr    = '0;
      bus2cac_data    = '0;
      mem_rd_req      = 1'b0;
      mem_wr_req      = 1'b0;
      mem_addr        = '0;
      mem_wdata       = '0;
      case (state)
         SNOOP: begin
            bus2cac_addr = addr_q;
            for (int unsigned i = 0; i < NUM_CACHE; i++) begin
               if (IDX_W'(i) != grant_q) bus2cac_bus_req[i] = code_q;
            end
         end
         WB: begin
            mem_wr_req = 1'b1;
            mem_addr   = addr_q;
            mem_wdata  = line_q;
         end
         MEM_RD: begin
            mem_rd_req = 1'b1;
            mem_addr   = addr_q;
         end
         RESP: begin
            bus2cac_bus_rsp[grant_q] = rsp_q;
            bus2cac_addr             = addr_q;
            bus2cac_data             = line_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed self-checking bench for snoop_bus_arbiter (4 caches, 512-bit lines).
module tb_snoop_bus_arbiter;

   localparam int NC    = 4;
   localparam int LW    = 512;
   localparam int BLK_W = 58;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic [NC-1:0][1:0]         cac2bus_bus_req;
   logic [NC-1:0][BLK_W-1:0]   cac2bus_addr;
   logic [NC-1:0][1:0]         cac2bus_bus_rsp;
   logic [NC-1:0]              cac2bus_write_back;
   logic [NC-1:0][LW-1:0]      cac2bus_data;
   logic [NC-1:0][1:0]         bus2cac_bus_req;
   logic [NC-1:0][1:0]         bus2cac_bus_rsp;
   logic [BLK_W-1:0]           bus2cac_addr;
   logic [LW-1:0]              bus2cac_data;
   logic                       mem_rd_req;
   logic                       mem_wr_req;
   logic [BLK_W-1:0]           mem_addr;
   logic [LW-1:0]              mem_wdata;
   logic                       mem_ack;
   logic [LW-1:0]              mem_rdata;

   int checks   = 0;
   int failures = 0;

   snoop_bus_arbiter #(
      .NUM_CACHE  (NC),
      .ADDR_WIDTH (64),
      .LINE_WIDTH (LW)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .cac2bus_bus_req    (cac2bus_bus_req),
      .cac2bus_addr       (cac2bus_addr),
      .cac2bus_bus_rsp    (cac2bus_bus_rsp),
      .cac2bus_write_back (cac2bus_write_back),
      .cac2bus_data       (cac2bus_data),
      .bus2cac_bus_req    (bus2cac_bus_req),
      .bus2cac_bus_rsp    (bus2cac_bus_rsp),
      .bus2cac_addr       (bus2cac_addr),
      .bus2cac_data       (bus2cac_data),
      .mem_rd_req         (mem_rd_req),
      .mem_wr_req         (mem_wr_req),
      .mem_addr           (mem_addr),
      .mem_wdata          (mem_wdata),
      .mem_ack            (mem_ack),
      .mem_rdata          (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_snoop_inputs();
      cac2bus_bus_rsp    = '0;
      cac2bus_write_back = '0;
      cac2bus_data       = '0;
   endtask

   task automatic test_reset();
      rst_n           = 1'b0;
      cac2bus_bus_req = '0;
      cac2bus_addr    = '0;
      clear_snoop_inputs();
      mem_ack         = 1'b0;
      mem_rdata       = '0;
      step();
      step();
      checks++;
      if ({bus2cac_bus_req, bus2cac_bus_rsp, bus2cac_addr, bus2cac_data,
           mem_rd_req, mem_wr_req, mem_addr, mem_wdata} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got req=%h rsp=%h rd=%b wr=%b, expected all zero",
                  bus2cac_bus_req, bus2cac_bus_rsp, mem_rd_req, mem_wr_req);
      end
      rst_n = 1'b1;
   endtask

   // Cache0 BUS_RD, nobody answers, memory acks after two wait cycles.
   task automatic test_mem_read();
      logic [LW-1:0] rd;
      rd = {64{8'hAB}};
      cac2bus_bus_req[0] = 2'd1;
      cac2bus_addr[0]    = 58'h40;
      step(); // SNOOP
      checks++;
      if (bus2cac_bus_req !== {2'd1, 2'd1, 2'd1, 2'd0} || bus2cac_addr !== 58'h40) begin
         failures++;
         $display("FAIL mr_snoop: got req=%h addr=%h, expected req=54 addr=40",
                  bus2cac_bus_req, bus2cac_addr);
      end
      step(); // MEM_RD wait 1
      checks++;
      if (mem_rd_req !== 1'b1 || mem_wr_req !== 1'b0 || mem_addr !== 58'h40) begin
         failures++;
         $display("FAIL mr_memreq: got rd=%b wr=%b addr=%h, expected rd=1 wr=0 addr=40",
                  mem_rd_req, mem_wr_req, mem_addr);
      end
      step(); // MEM_RD wait 2
      checks++;
      if (mem_rd_req !== 1'b1 || bus2cac_bus_rsp !== '0 || bus2cac_bus_req !== '0) begin
         failures++;
         $display("FAIL mr_hold: got rd=%b rsp=%h req=%h, expected rd=1 rsp=0 req=0",
                  mem_rd_req, bus2cac_bus_rsp, bus2cac_bus_req);
      end
      mem_ack   = 1'b1;
      mem_rdata = rd;
      step(); // RESP
      mem_ack   = 1'b0;
      mem_rdata = '0;
      checks++;
      if (bus2cac_bus_rsp !== {2'd0, 2'd0, 2'd0, 2'd2} || mem_rd_req !== 1'b0 ||
          bus2cac_addr !== 58'h40) begin
         failures++;
         $display("FAIL mr_resp: got rsp=%h rd=%b addr=%h, expected rsp=02 rd=0 addr=40",
                  bus2cac_bus_rsp, mem_rd_req, bus2cac_addr);
      end
      checks++;
      if (bus2cac_data !== rd) begin
         failures++;
         $display("FAIL mr_data: got %h expected %h", bus2cac_data, rd);
      end
      cac2bus_bus_req[0] = 2'd0;
      step(); // IDLE
      checks++;
      if ({bus2cac_bus_req, bus2cac_bus_rsp, mem_rd_req, mem_wr_req} !== '0) begin
         failures++;
         $display("FAIL mr_idle: got req=%h rsp=%h rd=%b wr=%b, expected zero",
                  bus2cac_bus_req, bus2cac_bus_rsp, mem_rd_req, mem_wr_req);
      end
   endtask

   // Cache1 BUS_RD; caches 2 and 3 both hit, lowest index (2) supplies the line.
   task automatic test_snoop_hit();
      logic [LW-1:0] d2;
      logic [LW-1:0] d3;
      d2 = {16{32'hD00D_0002}};
      d3 = {16{32'hD00D_0003}};
      cac2bus_bus_req[1] = 2'd1;
      cac2bus_addr[1]    = 58'h123;
      step(); // SNOOP
      checks++;
      if (bus2cac_bus_req !== {2'd1, 2'd1, 2'd0, 2'd1} || bus2cac_bus_rsp !== '0) begin
         failures++;
         $display("FAIL sh_snoop: got req=%h rsp=%h, expected req=51 rsp=0",
                  bus2cac_bus_req, bus2cac_bus_rsp);
      end
      cac2bus_bus_rsp[2] = 2'd1;
      cac2bus_data[2]    = d2;
      cac2bus_bus_rsp[3] = 2'd1;
      cac2bus_data[3]    = d3;
      step(); // RESP, third cycle counting the request cycle
      clear_snoop_inputs();
      checks++;
      if (bus2cac_bus_rsp !== {2'd0, 2'd0, 2'd1, 2'd0} || bus2cac_addr !== 58'h123) begin
         failures++;
         $display("FAIL sh_resp: got rsp=%h addr=%h, expected rsp=04 addr=123",
                  bus2cac_bus_rsp, bus2cac_addr);
      end
      checks++;
      if (bus2cac_data !== d2 || mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0) begin
         failures++;
         $display("FAIL sh_data: got data=%h rd=%b wr=%b, expected data=%h rd=0 wr=0",
                  bus2cac_data, mem_rd_req, mem_wr_req, d2);
      end
      cac2bus_bus_req[1] = 2'd0;
      step();
   endtask

   // Cache0 BUS_RDX; cache3 dirty (write-back wins over cache1's clean hit).
   task automatic test_writeback();
      logic [LW-1:0] w;
      w = {16{32'hBEEF_0003}};
      cac2bus_bus_req[0] = 2'd2;
      cac2bus_addr[0]    = 58'h77;
      step(); // SNOOP
      cac2bus_write_back[3] = 1'b1;
      cac2bus_bus_rsp[3]    = 2'd1;
      cac2bus_data[3]       = w;
      cac2bus_bus_rsp[1]    = 2'd1;
      cac2bus_data[1]       = {16{32'h1111_1111}};
      step(); // WB
      clear_snoop_inputs();
      checks++;
      if (mem_wr_req !== 1'b1 || mem_rd_req !== 1'b0 || mem_addr !== 58'h77 || mem_wdata !== w) begin
         failures++;
         $display("FAIL wb_req: got wr=%b rd=%b addr=%h wdata=%h, expected wr=1 rd=0 addr=77 wdata=%h",
                  mem_wr_req, mem_rd_req, mem_addr, mem_wdata, w);
      end
      step(); // WB held without ack
      checks++;
      if (mem_wr_req !== 1'b1 || bus2cac_bus_rsp !== '0) begin
         failures++;
         $display("FAIL wb_hold: got wr=%b rsp=%h, expected wr=1 rsp=0", mem_wr_req, bus2cac_bus_rsp);
      end
      mem_ack = 1'b1;
      step(); // RESP
      mem_ack = 1'b0;
      checks++;
      if (bus2cac_bus_rsp !== {2'd0, 2'd0, 2'd0, 2'd1} || bus2cac_data !== w || mem_wr_req !== 1'b0) begin
         failures++;
         $display("FAIL wb_resp: got rsp=%h wr=%b data=%h, expected rsp=01 wr=0 data=%h",
                  bus2cac_bus_rsp, mem_wr_req, bus2cac_data, w);
      end
      cac2bus_bus_req[0] = 2'd0;
      step();
   endtask

   // Cache2 BUS_UPGR, no responders: UPGR_ACK without any memory access.
   task automatic test_upgrade();
      cac2bus_bus_req[2] = 2'd3;
      cac2bus_addr[2]    = 58'h200;
      step(); // SNOOP
      checks++;
      if (bus2cac_bus_req !== {2'd3, 2'd0, 2'd3, 2'd3} || mem_rd_req !== 1'b0) begin
         failures++;
         $display("FAIL up_snoop: got req=%h rd=%b, expected req=cf rd=0", bus2cac_bus_req, mem_rd_req);
      end
      step(); // RESP
      checks++;
      if (bus2cac_bus_rsp !== {2'd0, 2'd3, 2'd0, 2'd0} || mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0) begin
         failures++;
         $display("FAIL up_resp: got rsp=%h rd=%b wr=%b, expected rsp=30 rd=0 wr=0",
                  bus2cac_bus_rsp, mem_rd_req, mem_wr_req);
      end
      cac2bus_bus_req[2] = 2'd0;
      step();
   endtask

   // All four request together from rr_ptr=0; cache0 keeps requesting after its response.
   task automatic test_round_robin();
      int order[$];
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int cyc;
      int idx;
      test_reset();
      for (int i = 0; i < NC; i++) begin
         cac2bus_bus_req[i] = 2'd3;
         cac2bus_addr[i]    = BLK_W'(i * 16 + 8);
      end
      cyc = 0;
      while (order.size() < 5 && cyc < 60) begin
         step();
         cyc++;
         if (bus2cac_bus_rsp !== '0) begin
            idx = -1;
            for (int i = 0; i < NC; i++) if (bus2cac_bus_rsp[i] != 2'd0) idx = i;
            order.push_back(idx);
            if (idx > 0) cac2bus_bus_req[idx] = 2'd0;
            if (order.size() == 5) cac2bus_bus_req = '0;
         end
      end
      cac2bus_bus_req = '0;
      checks++;
      if (order.size() != 5) begin
         failures++;
         $display("FAIL rr_count: got %0d responses expected 5", order.size());
      end
      for (int i = 0; i < 5; i++) begin
         if (i < order.size()) begin
            checks++;
            if (order[i] != exp_order[i]) begin
               failures++;
               $display("FAIL rr_order[%0d]: got cache %0d expected cache %0d", i, order[i], exp_order[i]);
            end
         end
      end
      step();
      step();
   endtask

   // Reset while waiting on memory aborts the transaction; later request served normally.
   task automatic test_reset_mid();
      logic [LW-1:0] rd;
      rd = {16{32'hCAFE_F00D}};
      cac2bus_bus_req[1] = 2'd1;
      cac2bus_addr[1]    = 58'h55;
      step(); // SNOOP
      step(); // MEM_RD
      checks++;
      if (mem_rd_req !== 1'b1) begin
         failures++;
         $display("FAIL rm_memrd: got rd=%b expected 1", mem_rd_req);
      end
      rst_n              = 1'b0;
      cac2bus_bus_req[1] = 2'd0;
      step();
      checks++;
      if ({bus2cac_bus_req, bus2cac_bus_rsp, bus2cac_addr, bus2cac_data,
           mem_rd_req, mem_wr_req, mem_addr, mem_wdata} !== '0) begin
         failures++;
         $display("FAIL rm_cleared: got rd=%b rsp=%h addr=%h, expected all zero",
                  mem_rd_req, bus2cac_bus_rsp, mem_addr);
      end
      rst_n     = 1'b1;
      mem_ack   = 1'b1; // stray ack while idle must be ignored
      mem_rdata = rd;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if ({bus2cac_bus_req, bus2cac_bus_rsp, mem_rd_req, mem_wr_req} !== '0) begin
            failures++;
            $display("FAIL rm_quiet[%0d]: got req=%h rsp=%h rd=%b wr=%b, expected zero",
                     c, bus2cac_bus_req, bus2cac_bus_rsp, mem_rd_req, mem_wr_req);
         end
      end
      cac2bus_bus_req[3] = 2'd2;
      cac2bus_addr[3]    = 58'h3AB;
      step(); // SNOOP
      step(); // MEM_RD, ack already high
      checks++;
      if (mem_rd_req !== 1'b1 || mem_addr !== 58'h3AB) begin
         failures++;
         $display("FAIL rm_new_mem: got rd=%b addr=%h, expected rd=1 addr=3ab", mem_rd_req, mem_addr);
      end
      step(); // RESP
      mem_ack = 1'b0;
      checks++;
      if (bus2cac_bus_rsp !== {2'd2, 2'd0, 2'd0, 2'd0} || bus2cac_data !== rd) begin
         failures++;
         $display("FAIL rm_new_resp: got rsp=%h data=%h, expected rsp=80 data=%h",
                  bus2cac_bus_rsp, bus2cac_data, rd);
      end
      cac2bus_bus_req[3] = 2'd0;
      step();
   endtask

   initial begin
      test_reset();
      test_mem_read();
      test_snoop_hit();
      test_writeback();
      test_upgrade();
      test_round_robin();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/snoop_bus_arbiter.md
SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_CACHE, default 4, number of attached cache_mem instances (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, CPU byte-address width.
REQ-003 SHALL have parameter LINE_WIDTH, default 512, cache line width in bits; BLK_W = ADDR_WIDTH-$clog2(LINE_WIDTH/8).
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port cac2bus_bus_req, input, [NUM_CACHE][2], per-cache bus request code.
REQ-007 SHALL have port cac2bus_addr, input, [NUM_CACHE][BLK_W], per-cache line address.
REQ-008 SHALL have port cac2bus_bus_rsp, input, [NUM_CACHE][2], per-cache snoop response.
REQ-009 SHALL have port cac2bus_write_back, input, [NUM_CACHE], per-cache dirty write-back flag.
REQ-010 SHALL have port cac2bus_data, input, [NUM_CACHE][LINE_WIDTH], per-cache line data.
REQ-011 SHALL have outputs bus2cac_bus_req [NUM_CACHE][2], bus2cac_bus_rsp [NUM_CACHE][2], bus2cac_addr BLK_W and bus2cac_data LINE_WIDTH (both broadcast).
REQ-012 SHALL have outputs mem_rd_req 1, mem_wr_req 1, mem_addr BLK_W, mem_wdata LINE_WIDTH; inputs mem_ack 1, mem_rdata LINE_WIDTH.

Function
REQ-013 Request codes SHALL be BUS_NO_REQ=0, BUS_RD=1, BUS_RDX=2, BUS_UPGR=3; response codes BUS_NO_RSP=0, BUS_SNOOP_FOUND_RSP=1, BUS_FETCH_MEM_RSP=2, BUS_UPGR_ACK_RSP=3.
REQ-014 FSM states SHALL be IDLE, SNOOP, WB, MEM_RD, RESP.
REQ-015 IDLE: any requester with code!=0 -> grant one by round-robin starting at rr_ptr, latch grant index, code and address, go SNOOP next cycle.
REQ-016 SNOOP (exactly 1 cycle): drive latched code on bus2cac_bus_req of every non-granted cache, latched address on bus2cac_addr; sample all cac2bus_bus_rsp, cac2bus_write_back, cac2bus_data in that cycle.
REQ-017 From SNOOP: any write_back -> WB; else any SNOOP_FOUND -> RESP(SNOOP_FOUND); else code BUS_UPGR -> RESP(UPGR_ACK); else -> MEM_RD.
REQ-018 Multiple responders SHALL select lowest cache index for data.
REQ-019 WB: hold mem_wr_req=1, mem_addr=latched address, mem_wdata=latched responder data until mem_ack; then RESP(SNOOP_FOUND, UPGR_ACK if code BUS_UPGR).
REQ-020 MEM_RD: hold mem_rd_req=1 until mem_ack; capture mem_rdata at ack; then RESP(FETCH_MEM).
REQ-021 RESP (exactly 1 cycle): bus2cac_bus_rsp[grant]=chosen code, bus2cac_addr=latched address, bus2cac_data=captured line; all other bus2cac_bus_rsp=0; then IDLE; rr_ptr=grant+1 mod NUM_CACHE.
REQ-022 Outside SNOOP all bus2cac_bus_req SHALL be 0; outside RESP all bus2cac_bus_rsp SHALL be 0; mem_rd_req/mem_wr_req never both 1.
REQ-023 Requester SHALL hold request until its RESP cycle; requests dropped before grant are ignored; request changes after grant are ignored.
REQ-024 Latency: uncontended snoop hit = 3 cycles request-to-RESP; memory path = 3 + mem_ack wait cycles.
REQ-025 mem_ack outside WB/MEM_RD SHALL be ignored.

Reset
REQ-026 While rst_n=0 at a clock edge: state=IDLE, rr_ptr=0, all outputs 0 from next cycle, including mid-transaction; in-flight transaction discarded, no RESP issued.

Structure
REQ-027 Request/response code constants and FSM state enum SHALL reside in shared package cache_bus_pkg, also used by cache_mem controllers.
REQ-028 Round-robin selection SHALL be sub-module rr_arbiter (NUM_CACHE req vector, ptr -> one-hot grant + index).

Verification
REQ-029 Cache0 BUS_RD addr 0x40, no responders -> mem_rd_req, mem_ack after 2 cycles with 0xAB.. -> cache0 gets FETCH_MEM, data 0xAB...
REQ-030 Cache1 BUS_RD, cache2 replies SNOOP_FOUND with data D -> cache1 gets SNOOP_FOUND, data D, 3 cycles after request, no memory access.
REQ-031 Cache0 BUS_RDX, cache3 write_back dirty D -> mem_wr_req with D until ack, then cache0 SNOOP_FOUND with D.
REQ-032 Caches 0..3 request same cycle, rr_ptr=0 -> RESP order 0,1,2,3; re-request by 0 after its RESP served after 1,2,3.
REQ-033 Cache2 BUS_UPGR, no responders -> UPGR_ACK, no memory access.
REQ-034 rst_n=0 during MEM_RD -> mem_rd_req 0 next cycle, state IDLE, no RESP; new request afterwards served normally.
